// File: rtl/ra_bist_pkg.sv
// Shared opcodes, enums and status field positions for the
// register-file March C- BIST engine.
package ra_bist_pkg;

    localparam logic [3:0] OP_ABORT = 4'h0;
    localparam logic [3:0] OP_START = 4'hF;

    typedef enum logic [2:0] {
        E0, E1, E2, E3, E4, E5
    } elem_t;

    typedef enum logic [1:0] {
        IDLE, RUN, DRAIN
    } state_t;

    localparam int ST_DONE = 31;
    localparam int ST_BUSY = 30;
    localparam int ST_FAIL = 29;
    localparam int ST_ELEM = 26;
    localparam int ST_PORT = 24;
    localparam int ST_ADR  = 8;
    localparam int ST_CNT  = 0;

endpackage

// File: rtl/ra_bist_march_cmp.sv
// Expected-data pipeline, per-port read comparators, first-fail
// capture and saturating failure counter.
module ra_bist_cmp
    import ra_bist_pkg::*;
#(
    parameter int DW    = 72,
    parameter int NRD   = 2,
    parameter int AW    = 6,
    parameter int RDLAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [DW-1:0]     in_exp,
    input  logic [AW-1:0]     in_adr,
    input  elem_t             in_elem,
    input  logic [NRD*DW-1:0] rd_dat,
    output logic [7:0]        fail_cnt,
    output logic [AW-1:0]     ff_adr,
    output elem_t             ff_elem,
    output logic [1:0]        ff_port
);

    logic          vld_q  [RDLAT];
    logic [DW-1:0] exp_q  [RDLAT];
    logic [AW-1:0] adr_q  [RDLAT];
    elem_t         elem_q [RDLAT];

    logic [NRD-1:0] miss;
    logic [1:0]     port;
    logic           hit;

    always_comb begin
        miss = '0;
        port = '0;
        for (int p = 0; p < NRD; p++)
            miss[p] = rd_dat[p*DW +: DW] != exp_q[RDLAT-1];
        // Scan downward so the lowest failing port wins.
        for (int p = NRD - 1; p >= 0; p--)
            if (miss[p]) port = 2'(p);
        hit = vld_q[RDLAT-1] && (|miss) && !flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fail_cnt <= '0;
            ff_adr   <= '0;
            ff_elem  <= E0;
            ff_port  <= '0;
            for (int i = 0; i < RDLAT; i++) begin
                vld_q[i]  <= 1'b0;
                exp_q[i]  <= '0;
                adr_q[i]  <= '0;
                elem_q[i] <= E0;
            end
        end else begin
            if (clr) begin
                fail_cnt <= '0;
                ff_adr   <= '0;
                ff_elem  <= E0;
                ff_port  <= '0;
            end else if (hit) begin
                if (fail_cnt != 8'hFF)
                    fail_cnt <= fail_cnt + 8'd1;
                if (fail_cnt == 8'd0) begin
                    ff_adr  <= adr_q[RDLAT-1];
                    ff_elem <= elem_q[RDLAT-1];
                    ff_port <= port;
                end
            end
            vld_q[0]  <= in_vld && !flush && !clr;
            exp_q[0]  <= in_exp;
            adr_q[0]  <= in_adr;
            elem_q[0] <= in_elem;
            for (int i = 1; i < RDLAT; i++) begin
                vld_q[i]  <= vld_q[i-1] && !flush && !clr;
                exp_q[i]  <= exp_q[i-1];
                adr_q[i]  <= adr_q[i-1];
                elem_q[i] <= elem_q[i-1];
            end
        end
    end

endmodule

// File: rtl/ra_bist_march.sv
// March C- BIST engine for register-file arrays; passes functional
// traffic through to the array macro while idle.
module ra_bist_march
    import ra_bist_pkg::*;
#(
    parameter int AW    = 6,
    parameter int DW    = 72,
    parameter int NRD   = 2,
    parameter int RDLAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctl_val,
    input  logic [31:0]       ctl,
    output logic [31:0]       status,
    input  logic [NRD-1:0]    rd_enb_in,
    input  logic [NRD*AW-1:0] rd_adr_in,
    input  logic              wr_enb_in,
    input  logic [AW-1:0]     wr_adr_in,
    input  logic [DW-1:0]     wr_dat_in,
    output logic [NRD-1:0]    rd_enb_out,
    output logic [NRD*AW-1:0] rd_adr_out,
    input  logic [NRD*DW-1:0] rd_dat,
    output logic              wr_enb_out,
    output logic [AW-1:0]     wr_adr_out,
    output logic [DW-1:0]     wr_dat_out
);

    localparam int            NB      = (DW + 7) / 8;
    localparam logic [AW-1:0] ADR_MAX = {AW{1'b1}};

    state_t        state;
    elem_t         elem;
    logic [AW-1:0] adr;
    logic          phase;
    logic [2:0]    drn;
    logic [7:0]    bg;
    logic          done;

    logic          eng_rd;
    logic          eng_wr;
    logic [AW-1:0] eng_rd_adr;
    logic [AW-1:0] eng_wr_adr;
    logic [DW-1:0] eng_wr_dat;

    logic [NB*8-1:0] rep;
    logic [NB*8-1:0] rep_new;
    logic [DW-1:0]   d0;
    logic [DW-1:0]   d0_new;
    logic [DW-1:0]   exp_dat;

    logic busy;
    logic cmd_abort;
    logic cmd_start;

    elem_t         n_elem;
    logic [AW-1:0] n_adr;
    logic          n_phase;
    logic          n_end;
    logic          n_rd;
    logic          rw;
    logic          down;
    logic          last;

    logic [7:0]    fail_cnt;
    logic [AW-1:0] ff_adr;
    elem_t         ff_elem;
    logic [1:0]    ff_port;

    assign busy      = state != IDLE;
    assign cmd_abort = ctl_val && ctl[31:28] == OP_ABORT;
    assign cmd_start = ctl_val && ctl[31:28] == OP_START && state == IDLE;

    always_comb begin
        rep     = {NB{bg}};
        rep_new = {NB{ctl[7:0]}};
        d0      = rep[DW-1:0];
        d0_new  = rep_new[DW-1:0];
        exp_dat = (elem == E2 || elem == E4) ? ~d0 : d0;
    end

    // Next operation: the counters always describe the op on the outputs.
    always_comb begin
        rw      = elem == E1 || elem == E2 || elem == E3 || elem == E4;
        down    = elem == E3 || elem == E4;
        last    = down ? (adr == '0) : (adr == ADR_MAX);
        n_elem  = elem;
        n_adr   = adr;
        n_phase = 1'b0;
        n_end   = 1'b0;
        if (rw && !phase) begin
            n_phase = 1'b1;
        end else if (!last) begin
            n_adr = down ? adr - 1'b1 : adr + 1'b1;
        end else begin
            case (elem)
                E0:      n_elem = E1;
                E1:      n_elem = E2;
                E2:      n_elem = E3;
                E3:      n_elem = E4;
                E4:      n_elem = E5;
                default: n_end  = 1'b1;
            endcase
            n_adr = (n_elem == E3 || n_elem == E4) ? ADR_MAX : '0;
        end
        n_rd = n_elem != E0 && (n_elem == E5 || !n_phase);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            elem       <= E0;
            adr        <= '0;
            phase      <= 1'b0;
            drn        <= '0;
            bg         <= '0;
            done       <= 1'b0;
            eng_rd     <= 1'b0;
            eng_wr     <= 1'b0;
            eng_rd_adr <= '0;
            eng_wr_adr <= '0;
            eng_wr_dat <= '0;
        end else if (cmd_abort) begin
            state  <= IDLE;
            eng_rd <= 1'b0;
            eng_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_start) begin
                    state      <= RUN;
                    bg         <= ctl[7:0];
                    done       <= 1'b0;
                    elem       <= E0;
                    adr        <= '0;
                    phase      <= 1'b0;
                    eng_rd     <= 1'b0;
                    eng_wr     <= 1'b1;
                    eng_wr_adr <= '0;
                    eng_wr_dat <= d0_new;
                end
                RUN: if (n_end) begin
                    state  <= DRAIN;
                    drn    <= '0;
                    eng_rd <= 1'b0;
                    eng_wr <= 1'b0;
                end else begin
                    elem   <= n_elem;
                    adr    <= n_adr;
                    phase  <= n_phase;
                    eng_rd <= n_rd;
                    eng_wr <= !n_rd;
                    if (n_rd) begin
                        eng_rd_adr <= n_adr;
                    end else begin
                        eng_wr_adr <= n_adr;
                        eng_wr_dat <= (n_elem == E1 || n_elem == E3) ? ~d0 : d0;
                    end
                end
                DRAIN: if (drn == 3'(RDLAT - 1)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else begin
                    drn <= drn + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ra_bist_cmp #(
        .DW(DW), .NRD(NRD), .AW(AW), .RDLAT(RDLAT)
    ) u_cmp (
        .clk      (clk),
        .reset    (reset),
        .clr      (cmd_start),
        .flush    (cmd_abort),
        .in_vld   (state == RUN && eng_rd),
        .in_exp   (exp_dat),
        .in_adr   (eng_rd_adr),
        .in_elem  (elem),
        .rd_dat   (rd_dat),
        .fail_cnt (fail_cnt),
        .ff_adr   (ff_adr),
        .ff_elem  (ff_elem),
        .ff_port  (ff_port)
    );

    always_comb begin
        status               = '0;
        status[ST_DONE]      = done;
        status[ST_BUSY]      = busy;
        status[ST_FAIL]      = fail_cnt != 8'd0;
        status[ST_ELEM +: 3] = ff_elem;
        status[ST_PORT +: 2] = ff_port;
        status[ST_ADR +: 8]  = 8'(ff_adr);
        status[ST_CNT +: 8]  = fail_cnt;
    end

    always_comb begin
        rd_enb_out = busy ? {NRD{eng_rd}} : rd_enb_in;
        rd_adr_out = busy ? {NRD{eng_rd_adr}} : rd_adr_in;
        wr_enb_out = busy ? eng_wr : wr_enb_in;
        wr_adr_out = busy ? eng_wr_adr : wr_adr_in;
        wr_dat_out = busy ? eng_wr_dat : wr_dat_in;
    end

endmodule
